mcoi_buffer_reader: RTL and testbench

Consumer-side burst reader for the `t_buffer` block-RAM interface. It sits opposite a buffer producer, such as the PS-shared BRAM holding motor profiles. On a start request it fetches `len_ib` consecutive 32-bit words from a word-aligned base address and delivers them on a valid/ready stream with full backpressure. Read latency is pipelined: one read is issued per cycle while downstream space allows, and a small skid FIFO absorbs data already in flight.

---
 rtl/mcoi_buffer_reader_pkg.sv | 24 ++
 rtl/mcoi_buffer_reader_if.sv | 19 +
 rtl/mcoi_skid_fifo.sv | 60 ++++++
 rtl/mcoi_buffer_reader.sv | 167 ++++++++++++++++
 tb/tb_mcoi_buffer_reader.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcoi_buffer_reader_pkg.sv
// Shared types and constants for the MCOI buffer reader.
package MCPkg;

  // Single clock plus asynchronous active-low reset
  typedef struct packed {
    logic clk;
    logic rst_n;
  } ckrs_t;

  // Reader FSM; the encoding is exported through the status register
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } bufread_state_t;

  // Status register bit positions
  localparam int unsigned STATUS_STATE_MSB = 31;
  localparam int unsigned STATUS_STATE_LSB = 30;
  localparam int unsigned STATUS_ABORT_BIT = 29;
  localparam int unsigned STATUS_COUNT_W   = 16;

endpackage

// File: rtl/mcoi_buffer_reader_if.sv
// Block-RAM buffer interface and 32-bit register interface.
interface t_buffer;
  logic        en;
  logic [31:0] addr;
  logic [3:0]  we;
  logic [31:0] din;
  logic [31:0] dout;

  modport consumer (output en, addr, we, din, input dout);
  modport producer (input en, addr, we, din, output dout);
endinterface

interface t_register;
  logic [31:0] status;
  logic [31:0] control;

  modport producer (output status, input control);
  modport consumer (input status, output control);
endinterface

// File: rtl/mcoi_skid_fifo.sv
// 32-bit synchronous FIFO of arbitrary depth with synchronous flush.
// Output data/valid come straight from the storage registers.
module mcoi_skid_fifo #(
  parameter int unsigned DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [31:0]                  push_data,
  input  logic                         pop,
  output logic [31:0]                  data,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count != CW'(DEPTH));
  assign data    = mem[rd_ptr];
  assign valid   = (count != '0);

  // Storage, pointers and occupancy; flush overrides any push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mcoi_buffer_reader.sv
// Burst reader for the t_buffer BRAM interface: fetches len_ib words from a
// word-aligned base and streams them out with full backpressure.
// Optional macro MCOI_BUFREAD_STATUS_EN adds the reg_x status/control port.
module mcoi_buffer_reader
  import MCPkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned LEN_W        = 12
) (
  input  ckrs_t             ClkRs_ix,
  t_buffer.consumer         buf_x,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [31:0]       base_addr_ib32,
  input  logic [LEN_W-1:0]  len_ib,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic [31:0]       data_ob32,
  output logic              valid_o,
  input  logic              ready_i
`ifdef MCOI_BUFREAD_STATUS_EN
  ,
  t_register.producer       reg_x
`endif
);

  localparam int unsigned FIFO_DEPTH = READ_LATENCY + 2;
  localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);

  logic                    clk;
  logic                    rst_n;
  bufread_state_t          state;
  bufread_state_t          state_next;
  logic [31:0]             addr;
  logic [LEN_W-1:0]        remaining;
  logic [READ_LATENCY-1:0] inflight;
  logic                    aborted_q;
  logic [CW-1:0]           fifo_count;
  logic [3:0]              outstanding;
  logic                    abort_req;
  logic                    abort_take;
  logic                    start_take;
  logic                    credit;
  logic                    issue;
  logic                    pop;
  logic                    drain_done;
  logic                    en;

  assign clk   = ClkRs_ix.clk;
  assign rst_n = ClkRs_ix.rst_n;

  assign outstanding = 4'($countones(inflight));
  assign credit      = (outstanding + 4'(fifo_count)) < 4'(FIFO_DEPTH);
  assign start_take  = start_i && (state == IDLE);
  assign abort_take  = abort_req && ((state == ISSUE) || (state == DRAIN));
  assign issue       = (state == ISSUE) && credit && !abort_req;
  assign pop         = valid_o && ready_i;
  // Leave DRAIN in the cycle the last word is handed over, so done_o
  // follows the final handshake by exactly one cycle.
  assign drain_done  = (outstanding == 4'd0) &&
                       ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

  assign buf_x.en   = en;
  assign buf_x.addr = addr;
  assign buf_x.we   = '0;
  assign buf_x.din  = '0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_i) state_next = (len_ib == '0) ? FINISH : ISSUE;
      ISSUE: begin
        if (abort_req)                                  state_next = FINISH;
        else if (issue && (remaining == LEN_W'(1)))     state_next = DRAIN;
      end
      DRAIN:   if (abort_req || drain_done) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    en        = 1'b0;
    busy_o    = start_take;
    done_o    = 1'b0;
    aborted_o = 1'b0;
    unique case (state)
      IDLE:    ;
      ISSUE: begin
        en     = issue;
        busy_o = 1'b1;
      end
      DRAIN:   busy_o = 1'b1;
      FINISH: begin
        done_o    = 1'b1;
        aborted_o = aborted_q;
      end
      default: ;
    endcase
  end

  // Address/length bookkeeping and the read-return tracking shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
      inflight  <= '0;
      aborted_q <= 1'b0;
    end else begin
      if (start_take) begin
        addr      <= {base_addr_ib32[31:2], 2'b00};
        remaining <= len_ib;
        aborted_q <= 1'b0;
      end else if (issue) begin
        addr      <= addr + 32'd4;
        remaining <= remaining - LEN_W'(1);
      end
      if (abort_take) begin
        inflight  <= '0;
        aborted_q <= 1'b1;
      end else begin
        inflight  <= (inflight << 1) | READ_LATENCY'(issue);
      end
    end
  end

  mcoi_skid_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort_take),
    .push      (inflight[READ_LATENCY-1]),
    .push_data (buf_x.dout),
    .pop       (pop),
    .data      (data_ob32),
    .valid     (valid_o),
    .count     (fifo_count)
  );

`ifdef MCOI_BUFREAD_STATUS_EN
  logic [STATUS_COUNT_W-1:0] delivered;

  // Words handed downstream in the current or last burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          delivered <= '0;
    else if (start_take) delivered <= '0;
    else if (pop)        delivered <= delivered + STATUS_COUNT_W'(1);
  end

  assign reg_x.status = {state, aborted_q,
                         {(STATUS_ABORT_BIT - STATUS_COUNT_W){1'b0}}, delivered};
  assign abort_req    = abort_i | reg_x.control[0];
`else
  assign abort_req    = abort_i;
`endif

endmodule

// File: tb/tb_mcoi_buffer_reader.sv
// Directed bench for mcoi_buffer_reader: one instance with READ_LATENCY=1,
// one with READ_LATENCY=3 for the backpressure scenario.
module tb_mcoi_buffer_reader;
  import MCPkg::*;

  logic  clk   = 1'b0;
  logic  rst_n = 1'b0;
  ckrs_t ckrs;
  int    cyc   = 0;
  int    n_tests = 0;
  int    n_fail  = 0;

  assign ckrs = '{clk: clk, rst_n: rst_n};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory content as a function of address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // ---------------- instance with READ_LATENCY = 1 ----------------
  t_buffer b1 ();
  logic        start1 = 1'b0, abort1 = 1'b0, ready1 = 1'b1;
  logic [31:0] base1  = '0;
  logic [11:0] len1   = '0;
  logic        busy1, done1, ab1, valid1;
  logic [31:0] data1;

  mcoi_buffer_reader #(.READ_LATENCY(1), .LEN_W(12)) dut1 (
    .ClkRs_ix(ckrs), .buf_x(b1), .start_i(start1), .abort_i(abort1),
    .base_addr_ib32(base1), .len_ib(len1), .busy_o(busy1), .done_o(done1),
    .aborted_o(ab1), .data_ob32(data1), .valid_o(valid1), .ready_i(ready1));

  always @(posedge clk) b1.dout <= b1.en ? mem_word(b1.addr) : 32'hBAD0_0000;

  // ---------------- instance with READ_LATENCY = 3 ----------------
  t_buffer b3 ();
  logic        start3 = 1'b0, abort3 = 1'b0, ready3 = 1'b1;
  logic [31:0] base3  = '0;
  logic [11:0] len3   = '0;
  logic        busy3, done3, ab3, valid3;
  logic [31:0] data3;
  logic [31:0] p3 [3];

  mcoi_buffer_reader #(.READ_LATENCY(3), .LEN_W(12)) dut3 (
    .ClkRs_ix(ckrs), .buf_x(b3), .start_i(start3), .abort_i(abort3),
    .base_addr_ib32(base3), .len_ib(len3), .busy_o(busy3), .done_o(done3),
    .aborted_o(ab3), .data_ob32(data3), .valid_o(valid3), .ready_i(ready3));

  always @(posedge clk) begin
    p3[0] <= b3.en ? mem_word(b3.addr) : 32'hBAD0_0000;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign b3.dout = p3[2];

  // ---------------- monitors (sample on falling edge) ----------------
  int          q_en1[$], q_hs1[$], q_done1[$];
  logic [31:0] q_addr1[$], q_data1[$];
  logic        q_dab1[$];
  int          q_en3[$], q_hs3[$], q_done3[$];
  logic [31:0] q_addr3[$], q_data3[$];
  logic        q_dab3[$];
  logic        pv3 = 1'b0, pr3 = 1'b0;
  logic [31:0] pd3 = '0;
  int          stall_viol3 = 0;
  int          fifo_max3   = 0;

  always @(negedge clk) begin
    if (b1.en === 1'b1) begin q_en1.push_back(cyc); q_addr1.push_back(b1.addr); end
    if (valid1 === 1'b1 && ready1 === 1'b1) begin q_hs1.push_back(cyc); q_data1.push_back(data1); end
    if (done1 === 1'b1) begin q_done1.push_back(cyc); q_dab1.push_back(ab1); end
    if (b3.en === 1'b1) begin q_en3.push_back(cyc); q_addr3.push_back(b3.addr); end
    if (valid3 === 1'b1 && ready3 === 1'b1) begin q_hs3.push_back(cyc); q_data3.push_back(data3); end
    if (done3 === 1'b1) begin q_done3.push_back(cyc); q_dab3.push_back(ab3); end
    if (pv3 && !pr3 && !(valid3 === 1'b1 && data3 === pd3)) stall_viol3++;
    pv3 = valid3; pr3 = ready3; pd3 = data3;
    if (int'(dut3.fifo_count) > fifo_max3) fifo_max3 = int'(dut3.fifo_count);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_en1.delete(); q_hs1.delete(); q_done1.delete(); q_addr1.delete(); q_data1.delete(); q_dab1.delete();
    q_en3.delete(); q_hs3.delete(); q_done3.delete(); q_addr3.delete(); q_data3.delete(); q_dab3.delete();
  endtask

  task automatic start_burst1(input logic [31:0] base, input int len, output int t);
    tick();
    start1 = 1'b1; base1 = base; len1 = 12'(len); t = cyc;
    tick();
    start1 = 1'b0;
  endtask

  task automatic wait_done1(input int limit);
    for (int i = 0; i < limit && q_done1.size() == 0; i++) tick();
  endtask

  // Checks that a completed dut1 burst delivered the expected addresses/words
  task automatic check_burst1(input string nm, input logic [31:0] base, input int len);
    n_tests++;
    if (q_addr1.size() != len) begin
      n_fail++; $display("FAIL %s_en_count: got %0d expected %0d", nm, q_addr1.size(), len);
    end
    n_tests++;
    if (q_data1.size() != len) begin
      n_fail++; $display("FAIL %s_word_count: got %0d expected %0d", nm, q_data1.size(), len);
    end
    for (int k = 0; k < len; k++) begin
      logic [31:0] ea;
      ea = base + 32'(4 * k);
      if (k < q_addr1.size()) begin
        n_tests++;
        if (q_addr1[k] !== ea) begin
          n_fail++; $display("FAIL %s_addr[%0d]: got %h expected %h", nm, k, q_addr1[k], ea);
        end
      end
      if (k < q_data1.size()) begin
        n_tests++;
        if (q_data1[k] !== mem_word(ea)) begin
          n_fail++; $display("FAIL %s_data[%0d]: got %h expected %h", nm, k, q_data1[k], mem_word(ea));
        end
      end
    end
    n_tests++;
    if (q_done1.size() != 1) begin
      n_fail++; $display("FAIL %s_done_count: got %0d expected 1", nm, q_done1.size());
    end else begin
      n_tests++;
      if (q_dab1[0] !== 1'b0) begin
        n_fail++; $display("FAIL %s_aborted: got %b expected 0", nm, q_dab1[0]);
      end
      if (q_hs1.size() != 0) begin
        n_tests++;
        if (q_done1[0] != q_hs1[q_hs1.size()-1] + 1) begin
          n_fail++; $display("FAIL %s_done_timing: got cycle %0d expected %0d", nm, q_done1[0], q_hs1[q_hs1.size()-1] + 1);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_tests++; if (b1.en !== 1'b0)      begin n_fail++; $display("FAIL reset_en: got %b expected 0", b1.en); end
    n_tests++; if (b1.addr !== 32'h0)   begin n_fail++; $display("FAIL reset_addr: got %h expected 0", b1.addr); end
    n_tests++; if (b1.we !== 4'h0)      begin n_fail++; $display("FAIL reset_we: got %h expected 0", b1.we); end
    n_tests++; if (b1.din !== 32'h0)    begin n_fail++; $display("FAIL reset_din: got %h expected 0", b1.din); end
    n_tests++; if (busy1 !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    n_tests++; if (done1 !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b expected 0", done1); end
    n_tests++; if (ab1 !== 1'b0)        begin n_fail++; $display("FAIL reset_aborted: got %b expected 0", ab1); end
    n_tests++; if (valid1 !== 1'b0)     begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid1); end
    n_tests++; if (data1 !== 32'h0)     begin n_fail++; $display("FAIL reset_data: got %h expected 0", data1); end
    n_tests++; if (valid3 !== 1'b0)     begin n_fail++; $display("FAIL reset_valid3: got %b expected 0", valid3); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int t;
    clear_q();
    ready1 = 1'b1;
    start_burst1(32'h0000_0100, 4, t);
    tick();
    @(negedge clk);
    n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy1); end
    wait_done1(40);
    tick();
    check_burst1("basic", 32'h0000_0100, 4);
    if (q_en1.size() == 4) begin
      n_tests++;
      if (q_en1[0] != t + 1 || q_en1[3] != t + 4) begin
        n_fail++; $display("FAIL basic_en_cycles: got %0d..%0d expected %0d..%0d", q_en1[0], q_en1[3], t + 1, t + 4);
      end
    end
    if (q_hs1.size() != 0) begin
      n_tests++;
      if (q_hs1[0] != t + 3) begin
        n_fail++; $display("FAIL basic_first_valid: got cycle %0d expected %0d", q_hs1[0], t + 3);
      end
    end
    if (q_done1.size() != 0) begin
      n_tests++;
      if (q_done1[0] != t + 7) begin
        n_fail++; $display("FAIL basic_done_cycle: got %0d expected %0d", q_done1[0], t + 7);
      end
    end
    @(negedge clk);
    n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b expected 0", busy1); end
  endtask

  task automatic test_zero_len();
    int t;
    clear_q();
    start_burst1(32'h0000_0800, 0, t);
    repeat (4) tick();
    n_tests++;
    if (q_en1.size() != 0) begin n_fail++; $display("FAIL zero_en: got %0d pulses expected 0", q_en1.size()); end
    n_tests++;
    if (q_data1.size() != 0) begin n_fail++; $display("FAIL zero_words: got %0d expected 0", q_data1.size()); end
    n_tests++;
    if (q_done1.size() != 1) begin
      n_fail++; $display("FAIL zero_done_count: got %0d expected 1", q_done1.size());
    end else begin
      n_tests++;
      if (q_done1[0] != t + 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d expected %0d", q_done1[0], t + 1); end
      n_tests++;
      if (q_dab1[0] !== 1'b0) begin n_fail++; $display("FAIL zero_aborted: got %b expected 0", q_dab1[0]); end
    end
  endtask

  task automatic test_wrap();
    int t;
    clear_q();
    start_burst1(32'hFFFF_FFF8, 4, t);
    wait_done1(40);
    tick();
    check_burst1("wrap", 32'hFFFF_FFF8, 4);
    clear_q();
    start_burst1(32'h0000_0203, 1, t);
    wait_done1(40);
    tick();
    check_burst1("align", 32'h0000_0200, 1);
  endtask

  task automatic test_abort();
    int t;
    clear_q();
    ready1 = 1'b1;
    start_burst1(32'h0000_1000, 16, t);
    repeat (5) tick();
    abort1 = 1'b1; ready1 = 1'b0;
    @(negedge clk);
    n_tests++; if (b1.en !== 1'b0) begin n_fail++; $display("FAIL abort_en_same_cycle: got %b expected 0", b1.en); end
    tick();
    abort1 = 1'b0; ready1 = 1'b1;
    @(negedge clk);
    n_tests++; if (valid1 !== 1'b0) begin n_fail++; $display("FAIL abort_valid_drop: got %b expected 0", valid1); end
    n_tests++; if (done1 !== 1'b1)  begin n_fail++; $display("FAIL abort_done: got %b expected 1", done1); end
    n_tests++; if (ab1 !== 1'b1)    begin n_fail++; $display("FAIL abort_aborted: got %b expected 1", ab1); end
    repeat (5) tick();
    n_tests++;
    if (q_en1.size() != 5) begin n_fail++; $display("FAIL abort_en_count: got %0d expected 5", q_en1.size()); end
    n_tests++;
    if (q_data1.size() != 3) begin n_fail++; $display("FAIL abort_word_count: got %0d expected 3", q_data1.size()); end
    for (int k = 0; k < 3 && k < q_data1.size(); k++) begin
      n_tests++;
      if (q_data1[k] !== mem_word(32'h1000 + 32'(4 * k))) begin
        n_fail++; $display("FAIL abort_data[%0d]: got %h expected %h", k, q_data1[k], mem_word(32'h1000 + 32'(4 * k)));
      end
    end
    n_tests++;
    if (q_done1.size() != 1 || q_done1[0] != t + 7) begin
      n_fail++; $display("FAIL abort_done_once: got %0d pulses expected 1 at cycle %0d", q_done1.size(), t + 7);
    end
    n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL abort_busy_after: got %b expected 0", busy1); end
    clear_q();
    start_burst1(32'h0000_0040, 2, t);
    wait_done1(40);
    tick();
    check_burst1("after_abort", 32'h0000_0040, 2);
  endtask

  task automatic test_reset_mid();
    int t;
    clear_q();
    start_burst1(32'h0000_0300, 16, t);
    repeat (3) tick();
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++; if (b1.en !== 1'b0)    begin n_fail++; $display("FAIL midrst_en: got %b expected 0", b1.en); end
    n_tests++; if (b1.addr !== 32'h0) begin n_fail++; $display("FAIL midrst_addr: got %h expected 0", b1.addr); end
    n_tests++; if (busy1 !== 1'b0)    begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy1); end
    n_tests++; if (done1 !== 1'b0)    begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done1); end
    n_tests++; if (valid1 !== 1'b0)   begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", valid1); end
    n_tests++; if (data1 !== 32'h0)   begin n_fail++; $display("FAIL midrst_data: got %h expected 0", data1); end
    tick();
    rst_n = 1'b1;
    tick();
    clear_q();
    start_burst1(32'h0000_0500, 2, t);
    wait_done1(40);
    tick();
    check_burst1("post_reset", 32'h0000_0500, 2);
  endtask

  task automatic test_backpressure();
    clear_q();
    stall_viol3 = 0;
    fifo_max3   = 0;
    ready3 = 1'b1;
    tick();
    start3 = 1'b1; base3 = 32'h0000_2000; len3 = 12'd8;
    tick();
    start3 = 1'b0;
    for (int i = 0; i < 200 && q_done3.size() == 0; i++) begin
      ready3 = ~ready3;
      tick();
    end
    ready3 = 1'b1;
    tick();
    n_tests++;
    if (q_addr3.size() != 8) begin n_fail++; $display("FAIL bp_en_count: got %0d expected 8", q_addr3.size()); end
    n_tests++;
    if (q_data3.size() != 8) begin n_fail++; $display("FAIL bp_word_count: got %0d expected 8", q_data3.size()); end
    for (int k = 0; k < 8 && k < q_data3.size(); k++) begin
      n_tests++;
      if (q_data3[k] !== mem_word(32'h2000 + 32'(4 * k))) begin
        n_fail++; $display("FAIL bp_data[%0d]: got %h expected %h", k, q_data3[k], mem_word(32'h2000 + 32'(4 * k)));
      end
    end
    n_tests++;
    if (stall_viol3 != 0) begin n_fail++; $display("FAIL bp_stall_hold: got %0d violations expected 0", stall_viol3); end
    n_tests++;
    if (fifo_max3 > 5) begin n_fail++; $display("FAIL bp_fifo_bound: got max %0d expected <= 5", fifo_max3); end
    n_tests++;
    if (q_done3.size() != 1) begin
      n_fail++; $display("FAIL bp_done_count: got %0d expected 1", q_done3.size());
    end else begin
      n_tests++;
      if (q_dab3[0] !== 1'b0) begin n_fail++; $display("FAIL bp_aborted: got %b expected 0", q_dab3[0]); end
      if (q_hs3.size() != 0) begin
        n_tests++;
        if (q_done3[0] != q_hs3[q_hs3.size()-1] + 1) begin
          n_fail++; $display("FAIL bp_done_timing: got %0d expected %0d", q_done3[0], q_hs3[q_hs3.size()-1] + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_backpressure();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
